// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the MEM stage.
// Holds a word-addressed RAM, inserts WAIT_CYCLES wait states per access,
// freezes the pipeline with stall while busy, and reports completion with a
// one-cycle ready pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (RAM contents preserved)
//   mem_read     load request
//   mem_write    store request (wins when both requests are asserted)
//   addr         byte address; word index is addr[ADDR_WIDTH+1:2]
//   wdata        store data
//   rdata        registered load data, holds the last completed read
//   ready        registered one-cycle completion pulse
//   stall        combinational pipeline freeze request
//   misalign_err registered, pulses with ready when addr[1:0] != 0
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        misalign_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                req;
  logic                accept;
  logic                fire;

  logic                op_write;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_W-1:0]   wdata_q;
  logic                misaligned;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign req   = mem_read | mem_write;
  assign stall = ((state == IDLE) && req) || (state == BUSY);

  // Next-state, wait counter, and strobes for latching and completing an access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          fire      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A request still held here belongs to the access just finished.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata        <= '0;
      ready        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ready        <= fire;
      misalign_err <= fire & misaligned;
      if (fire && !op_write) begin
        rdata <= misaligned ? '0 : mem[idx];
      end
    end
  end

  // Request capture at acceptance; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_write   <= mem_write;
      idx        <= addr[ADDR_WIDTH+1:2];
      wdata_q    <= wdata;
      misaligned <= (addr[1:0] != 2'b00);
    end
  end

  // RAM write port; not reset, and suppressed for misaligned or aborted stores.
  always_ff @(posedge clk) begin
    if (!reset && fire && op_write && !misaligned) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned WC    = 2;
  localparam int unsigned WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        ready, stall, misalign_err;

  logic        r0, w0;
  logic [31:0] a0, d0, rdata0;
  logic        ready0, stall0, mis0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .stall(stall), .misalign_err(misalign_err)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(r0), .mem_write(w0),
    .addr(a0), .wdata(d0), .rdata(rdata0), .ready(ready0),
    .stall(stall0), .misalign_err(mis0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a plain word array, index = (byte address / 4) mod depth.
  logic [31:0] model_mem [WORDS];
  logic [31:0] model_rdata;

  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp_rd,
                              output logic exp_mis);
    int unsigned i;
    i = (a / 4) % WORDS;
    exp_mis = (a % 4) != 0;
    if (wr) begin
      if (!exp_mis) model_mem[i] = d;
    end else if (rd) begin
      model_rdata = exp_mis ? 32'h0 : model_mem[i];
    end
    exp_rd = model_rdata;
  endtask

  // One full access on the WAIT_CYCLES=2 instance with timing and data checks.
  task automatic dut_access(input string name, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_mis);
    int stall_cnt;
    int rdy_cyc;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    stall_cnt = 0;
    rdy_cyc   = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (ready) begin
        rdy_cyc = c;
        break;
      end
      if (stall) stall_cnt++;
    end
    check({name, " ready_cycle"}, 32'(rdy_cyc), 32'(WC + 2));
    check({name, " stall_cycles"}, 32'(stall_cnt), 32'(WC + 2));
    check({name, " stall_in_done"}, {31'b0, stall}, 32'h0);
    check({name, " rdata"}, rdata, exp_rd);
    check({name, " misalign_err"}, {31'b0, misalign_err}, {31'b0, exp_mis});
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({name, " ready_width"}, {31'b0, ready}, 32'h0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_mis;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] er;
    logic        em;
    logic [31:0] ra;
    logic [31:0] rd_data;
    int          op;
    logic [5:0]  exp_stall0;
    logic [5:0]  exp_ready0;

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    model_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset rdata", rdata, 32'h0);
    check("reset ready", {31'b0, ready}, 32'h0);
    check("reset misalign", {31'b0, misalign_err}, 32'h0);
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset0 rdata", rdata0, 32'h0);
    check("reset0 stall", {31'b0, stall0}, 32'h0);

    // Bring every word to a known value.
    for (int i = 0; i < int'(WORDS); i++) begin
      model_access(1'b0, 1'b1, 32'(i * 4), 32'h0, er, em);
      dut_access("init", 1'b0, 1'b1, 32'(i * 4), 32'h0, er, em);
    end

    add_vec("wr_0x10",      1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    add_vec("rd_0x10",      1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add_vec("wr_0x404",     1'b0, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 1'b0);
    add_vec("rd_alias_0x4", 1'b1, 1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0);
    add_vec("wr_mis_0x22",  1'b0, 1'b1, 32'h22,  32'hAAAAAAAA, 32'h12345678, 1'b1);
    add_vec("rd_0x20",      1'b1, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0);
    add_vec("rd_0x10_b",    1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add_vec("rd_mis_0x21",  1'b1, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1);
    add_vec("rd_0x10_c",    1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add_vec("rw_both_0x30", 1'b1, 1'b1, 32'h30,  32'h77,       32'hDEADBEEF, 1'b0);
    add_vec("rd_0x30",      1'b1, 1'b0, 32'h30,  32'h0,        32'h77,       1'b0);
    add_vec("wr_0x8_old",   1'b0, 1'b1, 32'h8,   32'h11,       32'h77,       1'b0);
    add_vec("rd_0x8_old",   1'b1, 1'b0, 32'h8,   32'h0,        32'h11,       1'b0);

    foreach (vecs[k]) begin
      model_access(vecs[k].rd, vecs[k].wr, vecs[k].a, vecs[k].d, er, em);
      dut_access(vecs[k].name, vecs[k].rd, vecs[k].wr, vecs[k].a, vecs[k].d,
                 vecs[k].exp_rd, vecs[k].exp_mis);
    end

    // Reset during the second BUSY cycle of a store aborts it.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h8; wdata = 32'h55;
    @(negedge clk);
    check("abort busy1 stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort stall", {31'b0, stall}, 32'h0);
    check("abort ready", {31'b0, ready}, 32'h0);
    check("abort rdata", rdata, 32'h0);
    check("abort misalign", {31'b0, misalign_err}, 32'h0);
    model_rdata = '0;
    model_access(1'b1, 1'b0, 32'h8, 32'h0, er, em);
    dut_access("rd_after_abort", 1'b1, 1'b0, 32'h8, 32'h0, er, em);

    // Random traffic over a small aliased window, checked against the model.
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 2));
      ra = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rd_data = $urandom;
      model_access(op != 1, op != 0, ra, rd_data, er, em);
      dut_access("random", op != 1, op != 0, ra, rd_data, er, em);
    end

    // WAIT_CYCLES=0: request held through DONE is accepted again only from IDLE.
    exp_stall0 = 6'b011011;
    exp_ready0 = 6'b100100;
    @(negedge clk);
    w0 = 1'b1; a0 = 32'h40; d0 = 32'h99;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      check("w0 held stall", {31'b0, stall0}, {31'b0, exp_stall0[c]});
      check("w0 held ready", {31'b0, ready0}, {31'b0, exp_ready0[c]});
      if (c == 2) d0 = 32'hAA;
      if (c == 5) w0 = 1'b0;
    end
    @(negedge clk);
    check("w0 idle stall", {31'b0, stall0}, 32'h0);
    check("w0 idle ready", {31'b0, ready0}, 32'h0);

    r0 = 1'b1; a0 = 32'h40;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      check("r0 held stall", {31'b0, stall0}, {31'b0, exp_stall0[c]});
      check("r0 held ready", {31'b0, ready0}, {31'b0, exp_ready0[c]});
      if (exp_ready0[c]) check("r0 rdata", rdata0, 32'hAA);
      if (c == 5) r0 = 1'b0;
    end
    @(negedge clk);
    check("r0 idle ready", {31'b0, ready0}, 32'h0);
    check("r0 rdata hold", rdata0, 32'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving the MEM stage of the 5-stage pipeline. It is the slave end of the load/store interface driven by the MEM stage: `mem_read`, `mem_write`, `addr`, `wdata`.
- It holds a word-addressed RAM and inserts a configurable number of wait states.
- It raises `stall` to freeze the pipeline while an access is in flight, then returns `rdata` with a one-cycle `ready` pulse.

Parameters:
- ADDR_WIDTH, 8, log2 of RAM depth in 32-bit words (256 words).
- WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request from MEM stage.
- mem_write  in  1  store request from MEM stage.
- addr  in  32  byte address (MEM_ALUResult).
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- ready  out  1  one-cycle completion pulse, registered.
- stall  out  1  freeze request to PC, IF/ID, ID/EX, EX/MEM, MEM/WB enables.
- misalign_err  out  1  pulses with `ready` when addr[1:0] != 0.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, counter=0.
  - rdata=0, ready=0, misalign_err=0.
  - RAM contents are not cleared.
  - An in-flight access is aborted; a pending write is not performed.
- req = mem_read | mem_write.
- If both are asserted, the access is a write; the read is ignored.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^ADDR_WIDTH.
- FSM states IDLE, BUSY, DONE:
  - IDLE: when req=1, latch op/index/wdata/addr[1:0], load cnt=WAIT_CYCLES, go to BUSY.
  - BUSY: when cnt!=0, cnt-=1. When cnt==0, perform the access on this edge, set ready=1, go to DONE.
    - Write: RAM[index] <= latched wdata.
    - Read: rdata <= RAM[index].
  - DONE: ready=1 for exactly this cycle. Next state is IDLE unconditionally; the still-present old request is not re-accepted.
- stall (combinational) = (state==IDLE & req) | (state==BUSY). stall=0 in DONE.
- Latency: request first seen in cycle 0 gives stall high for WAIT_CYCLES+2 cycles and ready in cycle WAIT_CYCLES+2. With WAIT_CYCLES=2, ready is in cycle 4.
- Requester rules:
  - Hold mem_read/mem_write/addr/wdata stable while stall=1.
  - Values are latched at the IDLE edge; later changes are ignored.
  - The next request can be accepted at the earliest one cycle after DONE.
- Misaligned access (latched addr[1:0] != 0):
  - No RAM write.
  - On a read, rdata <= 0.
  - misalign_err=1 together with ready; timing is unchanged.
- rdata holds the last completed read value across writes and idle cycles.
- No request while in IDLE: stall=0, outputs hold.

Test Plan:
1. Reset, then write addr=0x10 data=0xDEADBEEF, then read addr=0x10. Required: stall high 4 cycles per access, ready pulses in cycle 4, rdata=0xDEADBEEF, misalign_err=0.
2. Aliasing (ADDR_WIDTH=8): write 0x12345678 to addr=0x404, then read addr=0x004. Required: rdata=0x12345678.
3. Misaligned: write 0xAAAAAAAA to addr=0x22, then read addr=0x20 (prior value 0x0) and read addr=0x21. Required: first read returns 0x0 (no write occurred); read at 0x21 gives misalign_err=1 with ready and rdata=0.
4. Reset mid-op: issue write 0x55 to addr=0x8 and assert reset in its 2nd BUSY cycle, then read addr=0x8. Required: after reset stall=0, ready=0, rdata=0; the read returns the old value, so the write is not performed.
5. Simultaneous mem_read=mem_write=1 to addr=0x30 with wdata=0x77, then read 0x30. Required: treated as write, rdata unchanged during that access, later read returns 0x77.
6. Back-to-back request held through DONE, with WAIT_CYCLES=0. Required: stall is 2 cycles per access, exactly one ready pulse per request, no double write or read on the DONE cycle.
